// File: rtl/spi_flash_controller.sv
// SPI master that serves instruction fetches from a serial flash and data
// accesses to a serial PSRAM over one shared mode-0 bus.

package spi_flash_pkg;
    typedef enum logic [1:0] {
        TYPE_IMEM_READ  = 2'd0,
        TYPE_DMEM_READ  = 2'd1,
        TYPE_DMEM_WRITE = 2'd2,
        TYPE_RESERVED   = 2'd3
    } mem_type_t;
endpackage

module spi_flash_controller
    import spi_flash_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset_in,
    output logic        sclk_out,
    output logic        flash_cs_out,
    output logic        psram_cs_out,
    output logic        mosi_out,
    input  logic        miso_in,
    input  logic [15:0] addr_in,
    input  logic        addr_valid_in,
    input  mem_type_t   mem_type_in,
    input  logic [7:0]  psram_data_in,
    output logic [15:0] flash_data_out,
    output logic        flash_data_valid_out,
    output logic [7:0]  psram_data_out,
    output logic        psram_data_valid_out,
    output logic        busy_out
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state;
    mem_type_t   cur_type;
    logic [47:0] tx_shift;
    logic [15:0] rx_shift;
    logic [5:0]  bits_left;

    logic        accept;
    logic [47:0] tx_frame;
    logic [15:0] rx_next;

    assign accept  = (state == IDLE) && addr_valid_in && (mem_type_in != TYPE_RESERVED);
    assign rx_next = {rx_shift[14:0], miso_in};

    // Frames are MSB-aligned in a 48-bit shifter; 40-bit PSRAM frames leave
    // the bottom byte unused since the bit counter stops before reaching it.
    always_comb begin
        tx_frame = '0;
        case (mem_type_in)
            TYPE_IMEM_READ:  tx_frame = {8'h03, 7'b0, addr_in, 1'b0, 16'h0000};
            TYPE_DMEM_READ:  tx_frame = {8'h03, 8'h00, addr_in, 8'h00, 8'h00};
            TYPE_DMEM_WRITE: tx_frame = {8'h02, 8'h00, addr_in, psram_data_in, 8'h00};
            default:         tx_frame = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state                <= IDLE;
            cur_type             <= TYPE_IMEM_READ;
            tx_shift             <= '0;
            rx_shift             <= '0;
            bits_left            <= '0;
            sclk_out             <= 1'b0;
            flash_cs_out         <= 1'b1;
            psram_cs_out         <= 1'b1;
            mosi_out             <= 1'b0;
            busy_out             <= 1'b0;
            flash_data_out       <= 16'h0000;
            flash_data_valid_out <= 1'b0;
            psram_data_out       <= 8'h00;
            psram_data_valid_out <= 1'b0;
        end else begin
            flash_data_valid_out <= 1'b0;
            psram_data_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHIFT;
                        cur_type     <= mem_type_in;
                        busy_out     <= 1'b1;
                        sclk_out     <= 1'b0;
                        mosi_out     <= tx_frame[47];
                        tx_shift     <= {tx_frame[46:0], 1'b0};
                        rx_shift     <= '0;
                        bits_left    <= (mem_type_in == TYPE_IMEM_READ) ? 6'd47 : 6'd39;
                        flash_cs_out <= (mem_type_in != TYPE_IMEM_READ);
                        psram_cs_out <= (mem_type_in == TYPE_IMEM_READ);
                    end
                end
                SHIFT: begin
                    if (!sclk_out) begin
                        sclk_out <= 1'b1;
                    end else begin
                        // End of the high phase: sample, then either move to the
                        // next bit or close the frame on this same edge.
                        sclk_out <= 1'b0;
                        rx_shift <= rx_next;
                        if (bits_left == 6'd0) begin
                            state        <= IDLE;
                            busy_out     <= 1'b0;
                            mosi_out     <= 1'b0;
                            flash_cs_out <= 1'b1;
                            psram_cs_out <= 1'b1;
                            if (cur_type == TYPE_IMEM_READ) begin
                                flash_data_out       <= {rx_next[7:0], rx_next[15:8]};
                                flash_data_valid_out <= 1'b1;
                            end else if (cur_type == TYPE_DMEM_READ) begin
                                psram_data_out       <= rx_next[7:0];
                                psram_data_valid_out <= 1'b1;
                            end
                        end else begin
                            bits_left <= bits_left - 6'd1;
                            mosi_out  <= tx_shift[47];
                            tx_shift  <= {tx_shift[46:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_controller.sv
// Randomized bench for spi_flash_controller with behavioural flash and PSRAM
// devices on the SPI bus and a request-level reference for read results.

module tb_spi_flash_controller;
    import spi_flash_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        sclk_out;
    logic        flash_cs_out;
    logic        psram_cs_out;
    logic        mosi_out;
    logic        miso_in = 1'b0;
    logic [15:0] addr_in = '0;
    logic        addr_valid_in = 1'b0;
    mem_type_t   mem_type_in = TYPE_IMEM_READ;
    logic [7:0]  psram_data_in = '0;
    logic [15:0] flash_data_out;
    logic        flash_data_valid_out;
    logic [7:0]  psram_data_out;
    logic        psram_data_valid_out;
    logic        busy_out;

    int compared = 0;
    int mismatched = 0;

    spi_flash_controller dut (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .sclk_out             (sclk_out),
        .flash_cs_out         (flash_cs_out),
        .psram_cs_out         (psram_cs_out),
        .mosi_out             (mosi_out),
        .miso_in              (miso_in),
        .addr_in              (addr_in),
        .addr_valid_in        (addr_valid_in),
        .mem_type_in          (mem_type_in),
        .psram_data_in        (psram_data_in),
        .flash_data_out       (flash_data_out),
        .flash_data_valid_out (flash_data_valid_out),
        .psram_data_out       (psram_data_out),
        .psram_data_valid_out (psram_data_valid_out),
        .busy_out             (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Flash contents: the two bytes the directed test relies on, a hash elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] ba);
        if (ba == 24'h000008) return 8'h34;
        if (ba == 24'h000009) return 8'h12;
        return ba[7:0] ^ ba[15:8] ^ {ba[16], 7'b0} ^ 8'hA5;
    endfunction

    // SPI-side PSRAM device storage, only changed by write frames seen on the bus.
    logic [7:0] psram_mem [int];
    // Request-side expectation of PSRAM contents, changed by issued writes.
    logic [7:0] psram_ref [int];

    function automatic logic [7:0] psram_dev(input logic [15:0] a);
        return psram_mem.exists(int'(a)) ? psram_mem[int'(a)] : 8'h00;
    endfunction

    function automatic logic [7:0] psram_expect(input logic [15:0] a);
        return psram_ref.exists(int'(a)) ? psram_ref[int'(a)] : 8'h00;
    endfunction

    int          fvalid_cnt = 0, pvalid_cnt = 0;
    int          flash_low_cnt = 0, psram_low_cnt = 0;
    int          frame_cnt = 0, idle_viol = 0;
    int          bit_k = 0, last_len = 0;
    logic [31:0] hdr = '0, last_hdr = '0;
    logic [7:0]  wbyte = '0, last_wbyte = '0;
    logic        prev_active = 1'b0, prev_psram = 1'b0;

    // Bus monitor and device models; each bit is seen once, mid sclk-high phase.
    always @(negedge clk_in) begin
        logic [7:0] b;
        int d;
        if (flash_data_valid_out) fvalid_cnt++;
        if (psram_data_valid_out) pvalid_cnt++;
        if (!flash_cs_out) flash_low_cnt++;
        if (!psram_cs_out) psram_low_cnt++;
        if (flash_cs_out && psram_cs_out) begin
            if (mosi_out !== 1'b0 || sclk_out !== 1'b0) idle_viol++;
            if (prev_active) begin
                frame_cnt++;
                last_len   = bit_k;
                last_hdr   = hdr;
                last_wbyte = wbyte;
                if (prev_psram && hdr[31:24] == 8'h02 && bit_k == 40)
                    psram_mem[int'(hdr[15:0])] = wbyte;
            end
            bit_k = 0; hdr = '0; wbyte = '0; miso_in = 1'b0; prev_active = 1'b0;
        end else begin
            prev_active = 1'b1;
            prev_psram  = !psram_cs_out;
            if (sclk_out) begin
                if (bit_k < 32) hdr = {hdr[30:0], mosi_out};
                else if (bit_k < 40) wbyte = {wbyte[6:0], mosi_out};
                miso_in = 1'b0;
                if (bit_k >= 32 && hdr[31:24] == 8'h03) begin
                    d = bit_k - 32;
                    if (!flash_cs_out) begin
                        b = flash_byte(hdr[23:0] + 24'(d / 8));
                        miso_in = b[7 - (d % 8)];
                    end else if (d < 8) begin
                        b = psram_dev(hdr[15:0]);
                        miso_in = b[7 - d];
                    end
                end
                bit_k++;
            end
        end
    end

    logic [15:0] exp_flash = 16'h0000;
    logic [7:0]  exp_psram = 8'h00;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input mem_type_t t, input logic [15:0] a, input logic [7:0] d, input bit noise);
        int s_fv, s_pv, s_fl, s_pl, s_fr, s_iv, cycles, n;
        logic [31:0] exp_hdr;
        s_fv = fvalid_cnt; s_pv = pvalid_cnt; s_fl = flash_low_cnt;
        s_pl = psram_low_cnt; s_fr = frame_cnt; s_iv = idle_viol;
        n = (t == TYPE_IMEM_READ) ? 48 : 40;
        @(negedge clk_in); #1;
        addr_valid_in = 1'b1; mem_type_in = t; addr_in = a; psram_data_in = d;
        @(negedge clk_in); #1;
        cycles = 0;
        while (busy_out && cycles < 200) begin
            cycles++;
            if (noise) begin
                addr_valid_in = 1'($urandom_range(0, 1));
                mem_type_in   = mem_type_t'($urandom_range(0, 3));
                addr_in       = 16'($urandom);
                psram_data_in = 8'($urandom);
            end else begin
                addr_valid_in = 1'b0;
            end
            @(negedge clk_in); #1;
        end
        addr_valid_in = 1'b0;
        @(negedge clk_in); #1;

        case (t)
            TYPE_IMEM_READ: begin
                exp_hdr   = {8'h03, 7'b0, a, 1'b0};
                exp_flash = {flash_byte({7'b0, a, 1'b0} + 24'd1), flash_byte({7'b0, a, 1'b0})};
            end
            TYPE_DMEM_READ: begin
                exp_hdr   = {8'h03, 8'h00, a};
                exp_psram = psram_expect(a);
            end
            default: begin
                exp_hdr = {8'h02, 8'h00, a};
                psram_ref[int'(a)] = d;
            end
        endcase

        checkOutput("busy_cycles", 64'(cycles), 64'(2 * n));
        checkOutput("frame_count", 64'(frame_cnt - s_fr), 64'd1);
        checkOutput("frame_bits", 64'(last_len), 64'(n));
        checkOutput("frame_header", 64'(last_hdr), 64'(exp_hdr));
        if (t == TYPE_DMEM_WRITE) checkOutput("write_byte", 64'(last_wbyte), 64'(d));
        checkOutput("flash_cs_low", 64'(flash_low_cnt - s_fl), (t == TYPE_IMEM_READ) ? 64'(2 * n) : 64'd0);
        checkOutput("psram_cs_low", 64'(psram_low_cnt - s_pl), (t != TYPE_IMEM_READ) ? 64'(2 * n) : 64'd0);
        checkOutput("flash_valid", 64'(fvalid_cnt - s_fv), (t == TYPE_IMEM_READ) ? 64'd1 : 64'd0);
        checkOutput("psram_valid", 64'(pvalid_cnt - s_pv), (t == TYPE_DMEM_READ) ? 64'd1 : 64'd0);
        checkOutput("idle_bus", 64'(idle_viol - s_iv), 64'd0);
        checkOutput("flash_data", 64'(flash_data_out), 64'(exp_flash));
        checkOutput("psram_data", 64'(psram_data_out), 64'(exp_psram));
    endtask

    initial begin
        int s_fl, s_pl, s_fv, busy_seen;
        mem_type_t t;

        #2 reset_in = 1'b0;
        #1;
        checkOutput("rst_flash_cs", 64'(flash_cs_out), 64'd1);
        checkOutput("rst_psram_cs", 64'(psram_cs_out), 64'd1);
        checkOutput("rst_sclk_mosi", 64'({sclk_out, mosi_out}), 64'd0);
        checkOutput("rst_busy_valid", 64'({busy_out, flash_data_valid_out, psram_data_valid_out}), 64'd0);
        checkOutput("rst_data", 64'({flash_data_out, psram_data_out}), 64'd0);
        repeat (3) @(negedge clk_in);
        reset_in = 1'b1;

        $display("[TB] directed transactions");
        applyStimulus(TYPE_IMEM_READ, 16'h0004, 8'h00, 1'b0);
        checkOutput("flash_1234", 64'(flash_data_out), 64'h1234);
        applyStimulus(TYPE_DMEM_READ, 16'h0004, 8'h00, 1'b0);
        applyStimulus(TYPE_DMEM_WRITE, 16'h0004, 8'h55, 1'b0);
        applyStimulus(TYPE_DMEM_READ, 16'h0004, 8'h00, 1'b1);
        checkOutput("psram_55", 64'(psram_data_out), 64'h55);
        applyStimulus(TYPE_IMEM_READ, 16'h0004, 8'h00, 1'b1);

        $display("[TB] reserved request");
        s_fl = flash_low_cnt; s_pl = psram_low_cnt; busy_seen = 0;
        @(negedge clk_in); #1;
        addr_valid_in = 1'b1; mem_type_in = TYPE_RESERVED; addr_in = 16'h0004;
        @(negedge clk_in); #1;
        addr_valid_in = 1'b0;
        repeat (4) begin
            if (busy_out) busy_seen++;
            @(negedge clk_in); #1;
        end
        checkOutput("reserved_busy", 64'(busy_seen), 64'd0);
        checkOutput("reserved_cs", 64'((flash_low_cnt - s_fl) + (psram_low_cnt - s_pl)), 64'd0);

        $display("[TB] reset mid-frame");
        s_fv = fvalid_cnt;
        @(negedge clk_in); #1;
        addr_valid_in = 1'b1; mem_type_in = TYPE_IMEM_READ; addr_in = 16'h0004;
        @(negedge clk_in); #1;
        addr_valid_in = 1'b0;
        repeat (39) @(negedge clk_in);
        #1 reset_in = 1'b0;
        #1;
        checkOutput("abort_flash_cs", 64'(flash_cs_out), 64'd1);
        checkOutput("abort_busy", 64'(busy_out), 64'd0);
        checkOutput("abort_sclk_mosi", 64'({sclk_out, mosi_out}), 64'd0);
        checkOutput("abort_data", 64'({flash_data_out, psram_data_out}), 64'd0);
        exp_flash = 16'h0000;
        exp_psram = 8'h00;
        repeat (3) @(negedge clk_in);
        #1 reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checkOutput("abort_no_valid", 64'(fvalid_cnt - s_fv), 64'd0);
        applyStimulus(TYPE_IMEM_READ, 16'h0004, 8'h00, 1'b0);
        checkOutput("post_abort_1234", 64'(flash_data_out), 64'h1234);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 30; i++) begin
            t = mem_type_t'($urandom_range(0, 2));
            applyStimulus(t, (i % 3 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom),
                          8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
